// File: rtl/ymul_seq_if.sv
// Bundle between the multiply sequencer, the CPU that requests products
// and the shared 32-bit ALU that performs each add step.
interface ymul_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_z;

    // Handshake: start is sampled only when busy=0 (idle or done cycle); a/b are
    // latched on that edge, and done pulses for one cycle when product is valid.
    modport slave (
        input  start, a, b, alu_z,
        output busy, done, product, alu_a, alu_b, alu_op
    );

    modport master (
        output start, a, b, alu_z,
        input  busy, done, product, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/ymul_seq.sv
// Shift-and-add unsigned multiplier that borrows the CPU ALU for one add per
// step and returns the low 32 bits of a*b after a fixed STEPS cycles.
module ymul_seq #(
    parameter int         STEPS  = 32,
    parameter int         CNT_W  = 6,
    parameter logic [2:0] ADD_OP = 3'b010
) (
    input  logic           clk,
    input  logic           reset,
    ymul_seq_if.slave      bus,
    output logic [1:0]     dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    state_t           state_q;
    logic [31:0]      acc_q;
    logic [31:0]      mcand_q;
    logic [31:0]      mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      product_q;
    logic             busy_q;
    logic             done_q;
    logic [31:0]      acc_d;

    // The ALU result is only folded in when the current multiplier bit is set.
    assign acc_d = mplier_q[0] ? bus.alu_z : acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        mcand_q  <= bus.a;
                        mplier_q <= bus.b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        product_q <= acc_d;
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.alu_a   = busy_q ? acc_q   : 32'd0;
    assign bus.alu_b   = busy_q ? mcand_q : 32'd0;
    assign bus.alu_op  = busy_q ? ADD_OP  : 3'b000;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ymul_seq.sv
// Bench for ymul_seq: vector table plus hand-written corner sequences, with a
// behavioural ALU and a scoreboard of expected products popped on each done.
module tb_ymul_seq;
    localparam int STEPS = 32;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    ymul_seq_if bus ();

    ymul_seq #(.STEPS(STEPS), .CNT_W(6), .ADD_OP(3'b010)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ALU model: add for op 010, anything else gives a visibly different result.
    assign bus.alu_z = (bus.alu_op == 3'b010) ? (bus.alu_a + bus.alu_b)
                                              : (bus.alu_a & bus.alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          exp_done = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("product_on_done", bus.product, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] exp_p, input int inject_at);
        logic [31:0] exp_acc;
        int          k;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = op_a;
        bus.b     = op_b;
        exp_q.push_back(exp_p);
        exp_done++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        exp_acc   = 32'd0;
        k         = 0;
        while (bus.busy === 1'b1 && k < 100) begin
            if (k < STEPS) begin
                check("alu_op_run", {29'd0, bus.alu_op}, 32'd2);
                check("alu_b_mcand", bus.alu_b, op_a << k);
                check("alu_a_acc", bus.alu_a, exp_acc);
                if (op_b[k]) exp_acc = exp_acc + (op_a << k);
            end
            if (k == inject_at) begin
                bus.start = 1'b1;
                bus.a     = 32'd100;
                bus.b     = 32'd100;
            end else begin
                bus.start = 1'b0;
            end
            k++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_cycles", k, STEPS);
        check("done_pulse", {31'd0, bus.done}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("idle_after_done", {31'd0, bus.busy}, 32'd0);
        check("product_held", bus.product, exp_p);
        check("alu_a_idle", bus.alu_a, 32'd0);
        check("alu_op_idle", {29'd0, bus.alu_op}, 32'd0);
    endtask

    initial begin
        int          k;
        int          gap;
        int          bc;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{32'd6,        32'd7,        32'd42};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[2] = '{32'h00010000, 32'h00010000, 32'h00000000};
        vecs[3] = '{32'h12345678, 32'h00000000, 32'h00000000};
        vecs[4] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[5] = '{32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF};
        vecs[6] = '{32'h00000001, 32'h80000000, 32'h80000000};
        vecs[7] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_product", bus.product, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_start", {31'd0, bus.busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, ra * rb, -1);
        end

        // start pulse mid-RUN must be ignored
        run_op(32'd3, 32'd5, 32'd15, 10);

        // back-to-back: start held through the done cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd2;
        bus.b     = 32'd9;
        exp_q.push_back(32'd18);
        exp_done++;
        @(negedge clk);
        check("b2b_state_run", {30'd0, dbg_state}, 32'd1);
        k = 0;
        while (bus.busy === 1'b1 && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("b2b_first_busy", k, STEPS);
        check("b2b_first_done", {31'd0, bus.done}, 32'd1);
        bus.a = 32'd4;
        bus.b = 32'd4;
        exp_q.push_back(32'd16);
        exp_done++;
        gap = 0;
        bc  = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) bus.start = 1'b0;
            if (bus.busy === 1'b1) bc++;
        end while (bus.done !== 1'b1 && gap < 100);
        check("b2b_gap", gap, STEPS + 1);
        check("b2b_second_busy", bc, STEPS);
        @(negedge clk);
        check("b2b_idle", {31'd0, bus.busy}, 32'd0);

        // reset at step 12 aborts the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_product", bus.product, 32'd0);
        check("abort_alu_a", bus.alu_a, 32'd0);
        check("abort_alu_b", bus.alu_b, 32'd0);
        check("abort_alu_op", {29'd0, bus.alu_op}, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", bus.product, 32'd0);
        run_op(32'd7, 32'd7, 32'd49, -1);

        repeat (3) @(negedge clk);
        check("done_count", n_done, exp_done);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
